// File: rtl/fetch_sequencer.sv
// Fetch decode and two-stage branch resolution in front of the program counter.
// JMP resolves in stage 2, conditional BRc in stage 3; wrong-path slots are squashed and counted.
module fetch_sequencer #(
  parameter int AW    = 8,
  parameter int NFLAG = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             BB,
  input  logic [15:0]      fetch_data,
  input  logic [AW-1:0]    pc_in,
  input  logic [NFLAG-1:0] flags,
  output logic             IPC,
  output logic             DIPC,
  output logic             LPC2,
  output logic             LPC3,
  output logic             EFL,
  output logic [AW-1:0]    UncondBranch,
  output logic [AW-1:0]    CondBranch,
  output logic [15:0]      ir2,
  output logic [15:0]      ir3,
  output logic             v2,
  output logic             v3,
  output logic [AW-1:0]    pc2,
  output logic [AW-1:0]    pc3,
  output logic [7:0]       squash_cnt
);

  logic [15:0]   r_ir2, r_ir3;
  logic          r_v2, r_v3;
  logic [AW-1:0] r_pc2, r_pc3;
  logic [7:0]    r_squash;

  logic          w_cond_true;
  logic          w_lpc2, w_lpc3;
  logic          w_flush;
  logic          w_advance;
  logic [1:0]    w_squash_inc;
  logic [8:0]    w_squash_sum;

  // Condition select lives in the low opcode bits: Z, C, N, always.
  always_comb begin
    w_cond_true = 1'b0;
    case (r_ir3[9:8])
      2'b00:   w_cond_true = flags[0];
      2'b01:   w_cond_true = flags[1];
      2'b10:   w_cond_true = flags[2];
      default: w_cond_true = 1'b1;
    endcase
  end

  assign w_lpc3    = r_v3 & (r_ir3[15:14] == 2'b11) & w_cond_true;
  // A taken stage-3 branch overrides a JMP sitting behind it.
  assign w_lpc2    = r_v2 & (r_ir2[15:14] == 2'b10) & ~w_lpc3;
  assign w_flush   = w_lpc2 | w_lpc3;
  // A branch load proceeds regardless of the bus-busy stall.
  assign w_advance = ~BB | w_flush;

  assign w_squash_inc = w_lpc3 ? 2'd2 : (w_lpc2 ? 2'd1 : 2'd0);
  assign w_squash_sum = {1'b0, r_squash} + {7'd0, w_squash_inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir2    <= '0;
      r_ir3    <= '0;
      r_v2     <= 1'b0;
      r_v3     <= 1'b0;
      r_pc2    <= '0;
      r_pc3    <= '0;
      r_squash <= '0;
    end else begin
      if (w_advance) begin
        r_ir3 <= r_ir2;
        r_v3  <= r_v2 & ~w_lpc3;
        r_pc3 <= r_pc2;
        r_ir2 <= fetch_data;
        r_pc2 <= pc_in;
        r_v2  <= ~w_flush;
      end
      r_squash <= w_squash_sum[8] ? 8'hFF : w_squash_sum[7:0];
    end
  end

  // Fetch acceptance is suppressed during a flush and while reset is held.
  assign IPC  = ~rst & ~w_flush & (fetch_data[15:14] == 2'b00);
  assign DIPC = ~rst & ~w_flush & (fetch_data[15:14] != 2'b00);

  assign LPC2         = w_lpc2;
  assign LPC3         = w_lpc3;
  assign EFL          = w_lpc3;
  assign UncondBranch = AW'(r_ir2[7:0]);
  assign CondBranch   = AW'(r_ir3[7:0]);
  assign ir2          = r_ir2;
  assign ir3          = r_ir3;
  assign v2           = r_v2;
  assign v3           = r_v3;
  assign pc2          = r_pc2;
  assign pc3          = r_pc3;
  assign squash_cnt   = r_squash;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer: pipeline flow, JMP/BRc squash, stall and saturation.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        BB;
  logic [15:0] fetch_data;
  logic [7:0]  pc_in;
  logic [2:0]  flags;
  logic        IPC, DIPC, LPC2, LPC3, EFL;
  logic [7:0]  UncondBranch, CondBranch;
  logic [15:0] ir2, ir3;
  logic        v2, v3;
  logic [7:0]  pc2, pc3;
  logic [7:0]  squash_cnt;
  logic [78:0] all_out;

  int checks;
  int failures;

  fetch_sequencer #(.AW(8), .NFLAG(3)) dut (
    .clk(clk), .rst(rst), .BB(BB), .fetch_data(fetch_data), .pc_in(pc_in), .flags(flags),
    .IPC(IPC), .DIPC(DIPC), .LPC2(LPC2), .LPC3(LPC3), .EFL(EFL),
    .UncondBranch(UncondBranch), .CondBranch(CondBranch),
    .ir2(ir2), .ir3(ir3), .v2(v2), .v3(v3), .pc2(pc2), .pc3(pc3),
    .squash_cnt(squash_cnt)
  );

  assign all_out = {IPC, DIPC, LPC2, LPC3, EFL, UncondBranch, CondBranch,
                    ir2, ir3, v2, v3, pc2, pc3, squash_cnt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; BB = 1'b0; fetch_data = 16'h0000; pc_in = 8'h00; flags = 3'b000;
    step(); step();
    checks++;
    if (all_out !== 79'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    $display("test_reset done");
  endtask

  task automatic test_flow();
    rst = 1'b0; fetch_data = 16'h0011; pc_in = 8'h00;
    #1;
    checks++;
    if ({IPC, DIPC} !== 2'b10) begin
      failures++; $display("FAIL flow_ipc0: got %b expected 10", {IPC, DIPC});
    end
    step();
    fetch_data = 16'h4005; pc_in = 8'h01;
    #1;
    checks++;
    if ({IPC, DIPC, v2, ir2} !== {3'b011, 16'h0011}) begin
      failures++; $display("FAIL flow_dipc1: got %b %b %b %h expected 0 1 1 0011", IPC, DIPC, v2, ir2);
    end
    step();
    fetch_data = 16'h0012; pc_in = 8'h03;
    #1;
    checks++;
    if ({IPC, DIPC, ir2, ir3} !== {2'b10, 16'h4005, 16'h0011}) begin
      failures++; $display("FAIL flow_ipc2: got %b%b %h %h expected 10 4005 0011", IPC, DIPC, ir2, ir3);
    end
    step();
    checks++;
    if ({ir3, pc3, v3, pc2} !== {16'h4005, 8'h01, 1'b1, 8'h03}) begin
      failures++; $display("FAIL flow_ir3: got ir3=%h pc3=%h v3=%b pc2=%h expected 4005 01 1 03", ir3, pc3, v3, pc2);
    end
    $display("test_flow done");
  endtask

  task automatic test_jmp();
    fetch_data = 16'h8040; pc_in = 8'h10;
    step();
    fetch_data = 16'h0099; pc_in = 8'h12;
    #1;
    checks++;
    if ({LPC2, LPC3, UncondBranch, IPC, DIPC} !== {2'b10, 8'h40, 2'b00}) begin
      failures++; $display("FAIL jmp_lpc2: got LPC2=%b LPC3=%b UB=%h IPC=%b DIPC=%b expected 1 0 40 0 0",
                           LPC2, LPC3, UncondBranch, IPC, DIPC);
    end
    step();
    checks++;
    if ({v2, v3, ir3, squash_cnt, LPC2} !== {2'b01, 16'h8040, 8'd1, 1'b0}) begin
      failures++; $display("FAIL jmp_after: got v2=%b v3=%b ir3=%h cnt=%0d LPC2=%b expected 0 1 8040 1 0",
                           v2, v3, ir3, squash_cnt, LPC2);
    end
    $display("test_jmp done");
  endtask

  task automatic test_brc(input logic [2:0] f, input logic taken, input logic [7:0] cnt_after);
    fetch_data = 16'hC028; pc_in = 8'h20; flags = 3'b000;
    step();
    fetch_data = 16'h0001; pc_in = 8'h22;
    step();
    fetch_data = 16'h0002; pc_in = 8'h23; flags = f;
    #1;
    checks++;
    if ({LPC3, EFL, CondBranch, IPC, v3} !== {taken, taken, 8'h28, ~taken, 1'b1}) begin
      failures++; $display("FAIL brc_lpc3 flags=%b: got LPC3=%b EFL=%b CB=%h IPC=%b v3=%b expected %b %b 28 %b 1",
                           f, LPC3, EFL, CondBranch, IPC, v3, taken, taken, ~taken);
    end
    step();
    flags = 3'b000;
    checks++;
    if ({v2, v3, squash_cnt} !== {~taken, ~taken, cnt_after}) begin
      failures++; $display("FAIL brc_after flags=%b: got v2=%b v3=%b cnt=%0d expected %b %b %0d",
                           f, v2, v3, squash_cnt, ~taken, ~taken, cnt_after);
    end
    $display("test_brc flags=%b done", f);
  endtask

  task automatic test_stall();
    BB = 1'b0;
    fetch_data = 16'h0021; pc_in = 8'h20;
    step();
    fetch_data = 16'h0022; pc_in = 8'h21;
    step();
    BB = 1'b1; fetch_data = 16'h0023; pc_in = 8'h22;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({ir2, ir3, pc2, IPC, v2, v3} !== {16'h0022, 16'h0021, 8'h21, 3'b111}) begin
        failures++; $display("FAIL stall_hold%0d: got ir2=%h ir3=%h pc2=%h IPC=%b v2=%b v3=%b expected 0022 0021 21 1 1 1",
                             i, ir2, ir3, pc2, IPC, v2, v3);
      end
    end
    BB = 1'b0;
    step();
    checks++;
    if ({ir2, ir3, pc2} !== {16'h0023, 16'h0022, 8'h22}) begin
      failures++; $display("FAIL stall_resume: got ir2=%h ir3=%h pc2=%h expected 0023 0022 22", ir2, ir3, pc2);
    end
    $display("test_stall done");
  endtask

  task automatic test_jmp_vs_brc();
    BB = 1'b0; flags = 3'b000;
    fetch_data = 16'hC300; pc_in = 8'h30;
    step();
    fetch_data = 16'h8050; pc_in = 8'h32;
    step();
    BB = 1'b1; fetch_data = 16'h0077; pc_in = 8'h34;
    #1;
    checks++;
    if ({LPC3, LPC2, EFL, CondBranch, UncondBranch} !== {3'b101, 8'h00, 8'h50}) begin
      failures++; $display("FAIL both_lpc: got LPC3=%b LPC2=%b EFL=%b CB=%h UB=%h expected 1 0 1 00 50",
                           LPC3, LPC2, EFL, CondBranch, UncondBranch);
    end
    step();
    checks++;
    if ({v2, v3, ir3, ir2, squash_cnt} !== {2'b00, 16'h8050, 16'h0077, 8'd5}) begin
      failures++; $display("FAIL both_after: got v2=%b v3=%b ir3=%h ir2=%h cnt=%0d expected 0 0 8050 0077 5",
                           v2, v3, ir3, ir2, squash_cnt);
    end
    BB = 1'b0;
    $display("test_jmp_vs_brc done");
  endtask

  task automatic run_brc_events(input int n);
    int events;
    int cyc;
    events = 0; cyc = 0;
    fetch_data = 16'hC300; BB = 1'b0; flags = 3'b000;
    while (events < n && cyc < 2000) begin
      if (LPC3) events++;
      step();
      cyc++;
    end
    checks++;
    if (events != n) begin
      failures++; $display("FAIL brc_events_timeout: got %0d events expected %0d", events, n);
    end
  endtask

  task automatic test_saturate();
    rst = 1'b1; step(); rst = 1'b0;
    run_brc_events(127);
    checks++;
    if (squash_cnt !== 8'd254) begin
      failures++; $display("FAIL sat_254: got %0d expected 254", squash_cnt);
    end
    run_brc_events(1);
    checks++;
    if (squash_cnt !== 8'd255) begin
      failures++; $display("FAIL sat_255: got %0d expected 255", squash_cnt);
    end
    run_brc_events(1);
    checks++;
    if (squash_cnt !== 8'd255) begin
      failures++; $display("FAIL sat_hold: got %0d expected 255", squash_cnt);
    end
    $display("test_saturate done");
  endtask

  task automatic test_reset_mid_branch();
    int cyc;
    cyc = 0;
    fetch_data = 16'hC300;
    while (!LPC3 && cyc < 10) begin
      step();
      cyc++;
    end
    checks++;
    if (LPC3 !== 1'b1) begin
      failures++; $display("FAIL midrst_setup: got LPC3=%b expected 1", LPC3);
    end
    rst = 1'b1;
    step();
    checks++;
    if (all_out !== 79'd0) begin
      failures++; $display("FAIL midrst_outputs: got %h expected 0", all_out);
    end
    rst = 1'b0;
    fetch_data = 16'h0011;
    #1;
    checks++;
    if ({IPC, LPC3} !== 2'b10) begin
      failures++; $display("FAIL midrst_first_fetch: got IPC=%b LPC3=%b expected 1 0", IPC, LPC3);
    end
    $display("test_reset_mid_branch done");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_flow();
    test_jmp();
    test_brc(3'b001, 1'b1, 8'd3);
    test_brc(3'b000, 1'b0, 8'd3);
    test_stall();
    test_jmp_vs_brc();
    test_saturate();
    test_reset_mid_branch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
